// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and constants for the counters family
package counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_count_core.sv
// rtl/updown_count_core.sv - WIDTH-bit loadable up/down count register with wrap detect
//
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   load/load_value synchronous load (has priority over enable)
//   enable, dir     step q by one in direction dir (1 = up, 0 = down)
//   q               registered count value
//   wrap            combinational: the step taken at the next edge wraps
module updown_count_core
    import counter_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] Q_MAX = '1;

    // A load is never a step, so it can never report a wrap.
    assign wrap = enable && !load &&
                  ((dir == DIR_UP && q == Q_MAX) || (dir == DIR_DOWN && q == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_value;
        end else if (enable) begin
            q <= (dir == DIR_UP) ? q + 1'b1 : q - 1'b1;
        end
    end

endmodule

// File: rtl/updown_count_sequencer.sv
// rtl/updown_count_sequencer.sv - command-driven up/down counter sequencer
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (ready while IDLE)
//   cmd_dir/start/steps/reload  command fields, sampled on acceptance
//   pause, abort                run-time controls, ignored in IDLE
//   q                           registered count value
//   busy                        high while a command is running
//   done, wrap                  one-cycle event pulses
module updown_count_sequencer
    import counter_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_steps,
    input  logic             cmd_reload,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    seq_state_t       state;
    logic [WIDTH-1:0] rem;
    logic             dir_lat;
    logic [WIDTH-1:0] start_lat;
    logic [WIDTH-1:0] steps_lat;
    logic             reload_lat;

    logic             accept;
    logic             active;
    logic             do_reload;
    logic             do_step;
    logic             step_wrap;

    assign cmd_ready = (state == IDLE);
    assign accept    = (state == IDLE) && cmd_valid;
    // RUN cycle that is neither aborted nor paused: either terminal or a step.
    assign active    = (state == RUN) && !abort && !pause;
    assign do_reload = active && (rem == '0) && reload_lat;
    assign do_step   = active && (rem != '0);

    updown_count_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (accept || do_reload),
        .load_value(accept ? cmd_start : start_lat),
        .enable    (do_step),
        .dir       (dir_lat),
        .q         (q),
        .wrap      (step_wrap)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rem        <= '0;
            dir_lat    <= 1'b0;
            start_lat  <= '0;
            steps_lat  <= '0;
            reload_lat <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            done <= 1'b0;
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        dir_lat    <= cmd_dir;
                        start_lat  <= cmd_start;
                        steps_lat  <= cmd_steps;
                        reload_lat <= cmd_reload;
                        rem        <= cmd_steps;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (pause) begin
                        // hold everything
                    end else if (rem == '0) begin
                        done <= 1'b1;
                        if (reload_lat) begin
                            rem <= steps_lat;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        rem  <= rem - 1'b1;
                        wrap <= step_wrap;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/updown_count_sequencer.md
# updown_count_sequencer

Synchronous, command-driven up/down counter controller for the counters family. It accepts one counting command at a time over a valid/ready handshake, then drives the count register one step per clock. Each command sets a start value, a direction, a step count and an auto-reload flag. It raises done/wrap event pulses and supports pause and abort. It is the sequenced, single-clock replacement for the ripple counters, for use where downstream logic needs deterministic cycle timing.

## Interface
- WIDTH, 3: count, start-value and step-count width; valid range 2-16.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; asserting it forces reset values immediately.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high exactly when the FSM is in IDLE.
- cmd_dir  in  1  1 = count up, 0 = count down.
- cmd_start  in  WIDTH  value loaded into q when the command is accepted.
- cmd_steps  in  WIDTH  number of count steps; 0 is legal.
- cmd_reload  in  1  1 = auto-reload at terminal count.
- pause  in  1  freezes q and the remaining-step count while in RUN.
- abort  in  1  synchronous cancel of the active command.
- q  out  WIDTH  count value, registered.
- busy  out  1  high while in RUN, registered.
- done  out  1  one-cycle pulse at terminal count, registered.
- wrap  out  1  one-cycle pulse after a step that wraps, registered.

## Operation
- States: IDLE, RUN.
- IDLE, cmd_valid=1 (cmd_ready=1): accept the command.
  - Latch cmd_dir, cmd_start, cmd_steps and cmd_reload.
  - q <= cmd_start, rem <= cmd_steps, go to RUN.
- IDLE, cmd_valid=0: q holds its value.
- Priority inside RUN: abort, then pause, then terminal check, then step.
- RUN, abort=1: go to IDLE. q holds its value; no done or wrap pulse.
- RUN, pause=1 (no abort): q, rem and state all hold.
- RUN, rem==0: done <= 1.
  - Reload flag clear: go to IDLE.
  - Reload flag set: q <= latched start, rem <= latched steps, stay in RUN.
- RUN, rem!=0: q <= q±1 modulo 2^WIDTH, rem <= rem-1.
  - wrap <= 1 when going up from 2^WIDTH-1 to 0, or down from 0 to 2^WIDTH-1.
- abort and pause are ignored in IDLE. A command presented together with abort in IDLE is accepted.
- Arithmetic: rem is WIDTH bits wide. All wrap is natural WIDTH-bit modulo; there is no saturation.
- Inputs are sampled only at the rising edge of clk. Command fields are ignored unless cmd_valid and cmd_ready are both high.

## Timing
- Reset values: q=0, state=IDLE, busy=0, done=0, wrap=0, rem=0, latched fields=0.
  - cmd_ready=1 during reset and immediately after it.
- Command accepted at edge T: q=cmd_start and busy=1 from T.
- With cmd_steps=N and no pause:
  - Steps occur at edges T+1 .. T+N.
  - done is high for the single cycle following edge T+N+1.
  - cmd_ready is back at 1 after edge T+N+1, so the next command can be accepted at edge T+N+2.
- Each paused RUN cycle delays done by exactly one cycle.
- wrap is high for the one cycle following the wrapping step.
- Auto-reload:
  - The reload cycle itself does not step q; the sequence repeats every N+1 cycles.
  - A reload edge never produces wrap, because it is a load, not a step.
- Reset asserted mid-run: outputs return to reset values asynchronously. The in-flight command is discarded.

## Structure
- Shared package `counter_pkg`:
  - State enum `seq_state_t` {IDLE, RUN}.
  - Direction constants DIR_UP=1 and DIR_DOWN=0.
- Sub-module `updown_count_core`: WIDTH-bit register with load, enable and dir inputs, producing q and a wrap flag. It contains no FSM.
- The sequencer owns the FSM, rem, the latched command fields, and the done/wrap output registers.

## Test plan
- Reset release, WIDTH=3 -> q=0, cmd_ready=1, busy=0, done=0, wrap=0.
- Up, start 2, steps 3 -> q 2,3,4,5 on successive cycles; done for one cycle; cmd_ready=1 the next cycle; no wrap.
- Down, start 1, steps 3 -> q 1,0,7,6; wrap pulses once, after 0→7; done once.
- Up, start 0, steps 4, pause held for 2 cycles after the second step -> q holds at 2 for 2 cycles; done arrives 2 cycles later than the unpaused case.
- Auto-reload, up, start 6, steps 2 -> q 6,7,0 (wrap),6 with done on the reload cycle, then 7,0,6... Abort mid-run -> IDLE next cycle, q held, no done; steps 0 -> done one cycle after acceptance, q=start.
- Reset pulsed low while q=5 mid-run -> q=0 and busy=0 immediately. A new command after release behaves as in the up, start 2, steps 3 scenario.
